// File: rtl/rs_alu_pkg.sv
// Shared types for the ALU reservation station: sizes, ALU opcodes, CDB packet and RS entry layout.
`default_nettype none

package rs_alu_pkg;

  localparam int XLEN    = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;
  localparam int RS_SIZE = 8;
  localparam int RS_LEN  = 3;

  localparam logic [XLEN-1:0] NOP_PC = 32'hfacebeec;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'h00,
    ALU_SUB  = 5'h01,
    ALU_SLT  = 5'h02,
    ALU_SLTU = 5'h03,
    ALU_AND  = 5'h04,
    ALU_OR   = 5'h05,
    ALU_XOR  = 5'h06,
    ALU_SLL  = 5'h07,
    ALU_SRL  = 5'h08,
    ALU_SRA  = 5'h09,
    ALU_MUL  = 5'h0a
  } ALU_FUNC;

  typedef struct packed {
    logic               valid;
    logic [PRF_LEN-1:0] dest;
    logic [XLEN-1:0]    value;
  } CDB_PACKET;

  typedef struct packed {
    logic               ready;
    logic [PRF_LEN-1:0] prf_idx;
    logic [XLEN-1:0]    value;
  } RS_OPERAND;

  typedef struct packed {
    logic               valid;
    ALU_FUNC            func;
    RS_OPERAND          opa;
    RS_OPERAND          opb;
    logic [PRF_LEN-1:0] dest;
    logic [ROB_LEN-1:0] rob;
    logic [XLEN-1:0]    pc;
  } RS_ALU_ENTRY;

  // Capture a broadcast value into an operand still waiting on that tag.
  function automatic RS_OPERAND wake_operand(input RS_OPERAND op, input CDB_PACKET cdb);
    RS_OPERAND res;
    res = op;
    if (!op.ready && cdb.valid && (op.prf_idx == cdb.dest)) begin
      res.ready = 1'b1;
      res.value = cdb.value;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/psel_gen.sv
// Priority selector: grants up to REQS of the lowest-index set request bits.
`default_nettype none

module psel_gen #(
  parameter int WIDTH = 8,
  parameter int REQS  = 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             empty
);

  logic [REQS:0][WIDTH-1:0] remain;

  assign remain[0] = req;

  for (genvar r = 0; r < REQS; r++) begin : g_req
    logic [WIDTH-1:0] pick;
    assign pick          = remain[r] & (~remain[r] + WIDTH'(1));
    assign remain[r+1]   = remain[r] & ~pick;
  end

  assign gnt   = req & ~remain[REQS];
  assign empty = ~|req;

endmodule

`default_nettype wire

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops, wakes operands from the CDB, issues lowest ready entry.
`default_nettype none

module rs_alu
  import rs_alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               commit_mis_pred,
  input  logic               disp_valid,
  input  logic [4:0]         disp_func,
  input  logic               disp_opa_ready,
  input  logic               disp_opb_ready,
  input  logic [PRF_LEN-1:0] disp_opa_prf_idx,
  input  logic [PRF_LEN-1:0] disp_opb_prf_idx,
  input  logic [XLEN-1:0]    disp_opa_value,
  input  logic [XLEN-1:0]    disp_opb_value,
  input  logic [PRF_LEN-1:0] disp_dest_prf_idx,
  input  logic [ROB_LEN-1:0] disp_rob_idx,
  input  logic [XLEN-1:0]    disp_PC,
  input  logic               cdb_broadcast_valid,
  input  logic [PRF_LEN-1:0] cdb_dest_preg_idx,
  input  logic [XLEN-1:0]    cdb_broadcast_value,
  input  logic               alu_ready,
  output logic               rs_full,
  output logic               issue_valid,
  output logic [4:0]         issue_func,
  output logic [XLEN-1:0]    issue_opa_value,
  output logic [XLEN-1:0]    issue_opb_value,
  output logic [PRF_LEN-1:0] issue_dest_prf_idx,
  output logic [ROB_LEN-1:0] issue_rob_idx,
  output logic [XLEN-1:0]    issue_PC
);

  RS_ALU_ENTRY        entries [RS_SIZE];
  RS_ALU_ENTRY        disp_entry;
  RS_ALU_ENTRY        issue_entry;
  CDB_PACKET          cdb;
  logic [RS_SIZE-1:0] valid_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] free_gnt;
  logic [RS_SIZE-1:0] issue_gnt;
  logic               free_empty;
  logic               issue_empty;
  logic               issue_fire;
  logic               disp_fire;

  assign cdb = '{valid: cdb_broadcast_valid, dest: cdb_dest_preg_idx, value: cdb_broadcast_value};

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entries[i].valid & entries[i].opa.ready & entries[i].opb.ready;
    end
  end

  // Allocation looks only at registered valid bits, so a slot freed this cycle is not reused.
  psel_gen #(.WIDTH(RS_SIZE), .REQS(1)) u_free_sel (
    .req   (~valid_vec),
    .gnt   (free_gnt),
    .empty (free_empty)
  );

  psel_gen #(.WIDTH(RS_SIZE), .REQS(1)) u_issue_sel (
    .req   (ready_vec),
    .gnt   (issue_gnt),
    .empty (issue_empty)
  );

  assign rs_full     = free_empty;
  assign issue_valid = ~issue_empty & ~commit_mis_pred;
  assign issue_fire  = issue_valid & alu_ready;
  assign disp_fire   = disp_valid & ~rs_full;

  always_comb begin
    disp_entry       = '0;
    disp_entry.valid = 1'b1;
    disp_entry.func  = ALU_FUNC'(disp_func);
    disp_entry.opa   = wake_operand('{ready: disp_opa_ready, prf_idx: disp_opa_prf_idx,
                                      value: disp_opa_value}, cdb);
    disp_entry.opb   = wake_operand('{ready: disp_opb_ready, prf_idx: disp_opb_prf_idx,
                                      value: disp_opb_value}, cdb);
    disp_entry.dest  = disp_dest_prf_idx;
    disp_entry.rob   = disp_rob_idx;
    disp_entry.pc    = disp_PC;
  end

  always_comb begin
    issue_entry = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_gnt[i]) issue_entry = entries[i];
    end
  end

  always_comb begin
    issue_func         = '0;
    issue_opa_value    = '0;
    issue_opb_value    = '0;
    issue_dest_prf_idx = '0;
    issue_rob_idx      = '0;
    issue_PC           = NOP_PC;
    if (issue_valid) begin
      issue_func         = issue_entry.func;
      issue_opa_value    = issue_entry.opa.value;
      issue_opb_value    = issue_entry.opb.value;
      issue_dest_prf_idx = issue_entry.dest;
      issue_rob_idx      = issue_entry.rob;
      issue_PC           = issue_entry.pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
    end else if (commit_mis_pred) begin
      for (int i = 0; i < RS_SIZE; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (entries[i].valid) begin
          entries[i].opa <= wake_operand(entries[i].opa, cdb);
          entries[i].opb <= wake_operand(entries[i].opb, cdb);
        end
        if (issue_fire && issue_gnt[i]) entries[i].valid <= 1'b0;
        if (disp_fire && free_gnt[i]) entries[i] <= disp_entry;
      end
    end
  end

endmodule

`default_nettype wire
